// File: rtl/button_hit_judge.sv
// button_hit_judge: player-input side of the LED-sweep reaction game.
// The raw active-low button passes through a two-flop synchroniser and a
// debouncer. Each new debounced press is then judged against the sweep
// position, which gives one registered hit or miss pulse and a saturating
// score.
// Optional feature macro: MISS_PENALTY_EN. When it is defined, each miss
// decrements the score, and the score cannot go below 0.
`timescale 1ns/1ps
module button_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POS_W           = 3,
  parameter int TARGET_POS      = 7,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button1,
  input  logic [POS_W-1:0]   pos,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               score_max,
  output logic               pressed
);

  localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POS_W-1:0]   TARGET    = POS_W'(TARGET_POS);
  localparam logic [SCORE_W-1:0] SCORE_TOP = {SCORE_W{1'b1}};

  typedef enum logic {ST_READY, ST_LOCKED} state_t;

  logic [1:0]         r_sync;
  logic               w_s;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pressed;
  logic               r_pressed_d;
  logic               w_press;
  logic               w_at_target;
  state_t             r_state;
  state_t             w_state_next;
  logic               w_hit_next;
  logic               w_miss_next;
  logic               r_hit;
  logic               r_miss;
  logic               r_window;
  logic [SCORE_W-1:0] r_score;

  // The synchroniser carries the raw button level. It resets to 1, which
  // means the button is released, so w_s is 1 while the button is pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], button1};
  end

  assign w_s = ~r_sync[1];

  // Debounce: a changed level must persist for DEBOUNCE_CYCLES consecutive edges before pressed follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else if (w_s == r_pressed) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_pressed <= w_s;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level, used to detect the rising edge (press event).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pressed_d <= 1'b0;
    else        r_pressed_d <= r_pressed;
  end

  assign w_press     = r_pressed & ~r_pressed_d;
  assign w_at_target = (pos == TARGET);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_READY;
    else        r_state <= w_state_next;
  end

  // Judge a press in READY, then stay LOCKED until the debounced release.
  always_comb begin
    w_state_next = r_state;
    w_hit_next   = 1'b0;
    w_miss_next  = 1'b0;
    case (r_state)
      ST_READY: begin
        if (w_press) begin
          if (w_at_target && !r_window) w_hit_next  = 1'b1;
          else                          w_miss_next = 1'b1;
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!r_pressed) w_state_next = ST_READY;
      end
      default: w_state_next = ST_READY;
    endcase
  end

  // Registered pulses. A hit sets the window flag, and the flag stays set
  // until pos leaves the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_window <= 1'b0;
    end else begin
      r_hit  <= w_hit_next;
      r_miss <= w_miss_next;
      if (w_hit_next)        r_window <= 1'b1;
      else if (!w_at_target) r_window <= 1'b0;
    end
  end

  // Score update. Hits count up and saturate at the top value.
`ifdef MISS_PENALTY_EN
  // Misses count down, with 0 as the floor.
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score <= '0;
    end else if (w_hit_next) begin
      if (r_score != SCORE_TOP) r_score <= r_score + SCORE_W'(1);
`ifdef MISS_PENALTY_EN
    end else if (w_miss_next) begin
      if (r_score != '0) r_score <= r_score - SCORE_W'(1);
`endif
    end
  end

  assign hit       = r_hit;
  assign miss      = r_miss;
  assign score     = r_score;
  assign score_max = (r_score == SCORE_TOP);
  assign pressed   = r_pressed;

endmodule
